// File: rtl/shop_pkg.sv
// Shared types and defaults for the shop controller's doorway sensing front end.
// Used by pir_direction_detector (optional stats counters: PIR_DIR_STATS_EN).
package shop_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_O1         = 3'd1,
    ST_O2         = 3'd2,
    ST_O3         = 3'd3,
    ST_I1         = 3'd4,
    ST_I2         = 3'd5,
    ST_I3         = 3'd6,
    ST_WAIT_CLEAR = 3'd7
  } pirState_t;

  localparam int PIR_DEBOUNCE_DEFAULT = 4;
  localparam int PIR_TIMEOUT_DEFAULT  = 1000;
  localparam int PIR_CNT_W            = 16;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [PIR_CNT_W-1:0] satInc(input logic [PIR_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/beam_debouncer.sv
// Two-flop synchroniser followed by a consecutive-sample debouncer for one
// raw beam input.
module beam_debouncer
  import shop_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = PIR_DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  logic       syncA;
  logic       syncB;
  logic [7:0] mismatchCnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      syncA       <= 1'b0;
      syncB       <= 1'b0;
      mismatchCnt <= '0;
      level       <= 1'b0;
    end else begin
      syncA <= raw;
      syncB <= syncA;
      // Any agreeing sample restarts the run of disagreeing samples.
      if (syncB == level) begin
        mismatchCnt <= '0;
      end else if (mismatchCnt == 8'(DEBOUNCE_CYCLES - 1)) begin
        level       <= syncB;
        mismatchCnt <= '0;
      end else begin
        mismatchCnt <= mismatchCnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/pir_direction_detector.sv
// Doorway direction detector: debounced outer/inner beams drive a crossing FSM
// that emits entry, exit and abort pulses. Define PIR_DIR_STATS_EN for counters.
module pir_direction_detector
  import shop_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = PIR_DEBOUNCE_DEFAULT,
  parameter int TIMEOUT_CYCLES  = PIR_TIMEOUT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 beamOuter,
  input  logic                 beamInner,
  output logic                 enterPulse,
  output logic                 exitPulse,
  output logic                 abortPulse,
  output logic                 busy,
  output logic [PIR_CNT_W-1:0] entryCount,
  output logic [PIR_CNT_W-1:0] exitCount
);

  logic      o;
  logic      i;
  pirState_t stateReg;
  pirState_t stateNext;
  logic [15:0] timerReg;
  logic      enterNext;
  logic      exitNext;
  logic      abortNext;
  logic      timedOut;

  beam_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) outerDeb (
    .clk(clk), .rst(rst), .raw(beamOuter), .level(o)
  );

  beam_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) innerDeb (
    .clk(clk), .rst(rst), .raw(beamInner), .level(i)
  );

  assign timedOut = (timerReg == 16'(TIMEOUT_CYCLES - 1));

  always_comb begin
    stateNext = stateReg;
    enterNext = 1'b0;
    exitNext  = 1'b0;
    abortNext = 1'b0;
    case (stateReg)
      ST_IDLE: begin
        if (o && i) begin
          stateNext = ST_WAIT_CLEAR;
          abortNext = 1'b1;
        end else if (o) begin
          stateNext = ST_O1;
        end else if (i) begin
          stateNext = ST_I1;
        end
      end
      ST_O1: begin
        if (i) stateNext = ST_O2;
        else if (!o) begin
          stateNext = ST_IDLE;
          abortNext = 1'b1;
        end
      end
      ST_O2: begin
        if (!o && i) stateNext = ST_O3;
        else if (o && !i) stateNext = ST_O1;
        else if (!o && !i) begin
          stateNext = ST_IDLE;
          abortNext = 1'b1;
        end
      end
      ST_O3: begin
        if (!o && !i) begin
          stateNext = ST_IDLE;
          enterNext = 1'b1;
        end else if (o) begin
          stateNext = ST_O2;
        end
      end
      ST_I1: begin
        if (o) stateNext = ST_I2;
        else if (!i) begin
          stateNext = ST_IDLE;
          abortNext = 1'b1;
        end
      end
      ST_I2: begin
        if (!i && o) stateNext = ST_I3;
        else if (i && !o) stateNext = ST_I1;
        else if (!i && !o) begin
          stateNext = ST_IDLE;
          abortNext = 1'b1;
        end
      end
      ST_I3: begin
        if (!i && !o) begin
          stateNext = ST_IDLE;
          exitNext  = 1'b1;
        end else if (i) begin
          stateNext = ST_I2;
        end
      end
      ST_WAIT_CLEAR: begin
        if (!o && !i) stateNext = ST_IDLE;
      end
      default: stateNext = ST_IDLE;
    endcase
    // A stall only aborts when no real transition happened this cycle.
    if (stateNext == stateReg && stateReg != ST_IDLE &&
        stateReg != ST_WAIT_CLEAR && timedOut) begin
      stateNext = ST_WAIT_CLEAR;
      abortNext = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg   <= ST_IDLE;
      timerReg   <= '0;
      enterPulse <= 1'b0;
      exitPulse  <= 1'b0;
      abortPulse <= 1'b0;
      busy       <= 1'b0;
    end else begin
      stateReg   <= stateNext;
      enterPulse <= enterNext;
      exitPulse  <= exitNext;
      abortPulse <= abortNext;
      busy       <= (stateNext != ST_IDLE);
      if (stateNext != stateReg || stateNext == ST_IDLE || stateNext == ST_WAIT_CLEAR)
        timerReg <= '0;
      else
        timerReg <= timerReg + 16'd1;
    end
  end

`ifdef PIR_DIR_STATS_EN
  logic [PIR_CNT_W-1:0] entryCountReg;
  logic [PIR_CNT_W-1:0] exitCountReg;

  // Counters update on the same edge that raises the matching pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      entryCountReg <= '0;
      exitCountReg  <= '0;
    end else begin
      if (enterNext) entryCountReg <= satInc(entryCountReg);
      if (exitNext)  exitCountReg  <= satInc(exitCountReg);
    end
  end

  assign entryCount = entryCountReg;
  assign exitCount  = exitCountReg;
`else
  assign entryCount = '0;
  assign exitCount  = '0;
`endif

endmodule

// File: tb/tb_pir_direction_detector.sv
// Self-checking bench for pir_direction_detector: directed doorway scenarios plus
// random beam activity, compared each cycle against a crossing-level model.
module tb_pir_direction_detector;
  import shop_pkg::*;

  localparam int DEB = 4;
  localparam int TO  = 50;
`ifdef PIR_DIR_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic beamOuter;
  logic beamInner;
  logic enterPulse, exitPulse, abortPulse, busy;
  logic [15:0] entryCount, exitCount;

  always #5 clk = ~clk;

  pir_direction_detector #(.DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .beamOuter(beamOuter), .beamInner(beamInner),
    .enterPulse(enterPulse), .exitPulse(exitPulse), .abortPulse(abortPulse),
    .busy(busy), .entryCount(entryCount), .exitCount(exitCount)
  );

  int checks = 0;
  int errors = 0;

  // Model state: raw sample histories, debounced levels, crossing progress.
  logic histO[$];
  logic histI[$];
  logic mDebO, mDebI;
  int   mPhase;   // 0 idle, 1 crossing in progress, 2 waiting for doorway to clear
  logic mLeadO;   // crossing started on the outer beam
  int   mStep;    // 1 lead only, 2 both, 3 trail only
  int   mDwell;
  logic mEnter, mExit, mAbort;
  logic [15:0] mEntry, mExitCnt;

  // Observed DUT activity, per scenario.
  int cyc = 0;
  int dEnter, dExit, dAbort, busySeen;
  int lastEnterCyc, lastAbortCyc, busyRiseCyc;
  logic prevBusy = 1'b0;
  int refCyc;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Debounced level flips once the synchronised samples (raw delayed by two
  // edges) have all disagreed with it for DEB consecutive cycles.
  function automatic logic debNext(input logic h[$], input logic cur);
    int n = h.size();
    if (n < DEB + 2) return cur;
    for (int j = n - DEB - 2; j <= n - 3; j++)
      if (h[j] == cur) return cur;
    return !cur;
  endfunction

  task automatic fsmStep(input logic o, input logic i);
    logic lead, trail;
    int prevStep;
    if (mPhase == 0) begin
      if (o && i) begin mPhase = 2; mAbort = 1'b1; end
      else if (o || i) begin mPhase = 1; mLeadO = o; mStep = 1; mDwell = 0; end
    end else if (mPhase == 2) begin
      if (!o && !i) mPhase = 0;
    end else begin
      lead  = mLeadO ? o : i;
      trail = mLeadO ? i : o;
      prevStep = mStep;
      case (mStep)
        1: if (trail) mStep = 2; else if (!lead) mStep = 0;
        2: if (!lead && trail) mStep = 3;
           else if (lead && !trail) mStep = 1;
           else if (!lead && !trail) mStep = 0;
        default: if (!lead && !trail) mStep = 4; else if (lead) mStep = 2;
      endcase
      if (mStep == 0) begin mPhase = 0; mAbort = 1'b1; end
      else if (mStep == 4) begin
        mPhase = 0;
        if (mLeadO) mEnter = 1'b1; else mExit = 1'b1;
      end else if (mStep != prevStep) mDwell = 0;
      else begin
        mDwell++;
        if (mDwell == TO) begin mPhase = 2; mAbort = 1'b1; end
      end
    end
    if (STATS != 0) begin
      if (mEnter && mEntry != 16'hFFFF) mEntry++;
      if (mExit && mExitCnt != 16'hFFFF) mExitCnt++;
    end
  endtask

  task automatic tick(input logic o, input logic i, input logic r);
    beamOuter = o;
    beamInner = i;
    rst = r;
    @(posedge clk);
    cyc++;
    mEnter = 1'b0; mExit = 1'b0; mAbort = 1'b0;
    if (r) begin
      histO.delete(); histI.delete();
      mDebO = 1'b0; mDebI = 1'b0; mPhase = 0; mDwell = 0;
      mEntry = '0; mExitCnt = '0;
    end else begin
      histO.push_back(o); histI.push_back(i);
      if (histO.size() > 32) begin void'(histO.pop_front()); void'(histI.pop_front()); end
      fsmStep(mDebO, mDebI);
      mDebO = debNext(histO, mDebO);
      mDebI = debNext(histI, mDebI);
    end
    @(negedge clk);
    check("enterPulse", 16'(enterPulse), 16'(mEnter));
    check("exitPulse", 16'(exitPulse), 16'(mExit));
    check("abortPulse", 16'(abortPulse), 16'(mAbort));
    check("busy", 16'(busy), 16'(mPhase != 0));
    check("entryCount", entryCount, mEntry);
    check("exitCount", exitCount, mExitCnt);
    if (enterPulse === 1'b1) begin dEnter++; lastEnterCyc = cyc; end
    if (exitPulse === 1'b1) dExit++;
    if (abortPulse === 1'b1) begin dAbort++; lastAbortCyc = cyc; end
    if (busy === 1'b1) busySeen++;
    if (busy === 1'b1 && prevBusy !== 1'b1) busyRiseCyc = cyc;
    prevBusy = busy;
  endtask

  task automatic hold(input logic o, input logic i, input int n);
    for (int k = 0; k < n; k++) tick(o, i, 1'b0);
  endtask

  task automatic clrObs();
    dEnter = 0; dExit = 0; dAbort = 0; busySeen = 0;
    lastEnterCyc = -1; lastAbortCyc = -1; busyRiseCyc = -1;
  endtask

  initial begin
    logic ro, ri;
    clrObs();
    // Reset state
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    check("reset.busy", 16'(busy), 16'd0);
    check("reset.entryCount", entryCount, 16'd0);
    hold(1'b0, 1'b0, 10);

    // Clean entry
    clrObs();
    refCyc = cyc;
    hold(1'b1, 1'b0, 20);
    hold(1'b1, 1'b1, 20);
    hold(1'b0, 1'b1, 20);
    check("entry.busyRise", 16'(busyRiseCyc - refCyc), 16'd7);
    refCyc = cyc;
    hold(1'b0, 1'b0, 20);
    check("entry.enterCount", 16'(dEnter), 16'd1);
    check("entry.latency", 16'(lastEnterCyc - refCyc), 16'd7);
    check("entry.noExitAbort", 16'(dExit + dAbort), 16'd0);
    check("entry.entryCount", entryCount, 16'(STATS));

    // Clean exit
    clrObs();
    hold(1'b0, 1'b1, 20);
    hold(1'b1, 1'b1, 20);
    hold(1'b1, 1'b0, 20);
    hold(1'b0, 1'b0, 20);
    check("exit.exitCount", 16'(dExit), 16'd1);
    check("exit.noEnter", 16'(dEnter), 16'd0);

    // Back-out
    clrObs();
    hold(1'b1, 1'b0, 20);
    hold(1'b0, 1'b0, 20);
    check("backout.abort", 16'(dAbort), 16'd1);
    check("backout.noCross", 16'(dEnter + dExit), 16'd0);
    check("backout.entryCount", entryCount, 16'(STATS));

    // Glitch rejection
    clrObs();
    for (int k = 0; k < 6; k++) begin
      hold(1'b1, 1'b0, 3);
      hold(1'b0, 1'b0, 6);
    end
    check("glitch.busy", 16'(busySeen), 16'd0);
    check("glitch.pulses", 16'(dEnter + dExit + dAbort), 16'd0);

    // Timeout
    clrObs();
    hold(1'b1, 1'b0, 200);
    check("timeout.latency", 16'(lastAbortCyc - busyRiseCyc), 16'd50);
    check("timeout.busyHeld", 16'(busy), 16'd1);
    hold(1'b0, 1'b0, 20);
    check("timeout.busyCleared", 16'(busy), 16'd0);
    check("timeout.abort", 16'(dAbort), 16'd1);

    // Simultaneous block
    clrObs();
    hold(1'b1, 1'b1, 20);
    hold(1'b0, 1'b0, 20);
    check("simul.abort", 16'(dAbort), 16'd1);

    // Reset mid-crossing while in the trail-only step
    clrObs();
    hold(1'b1, 1'b0, 15);
    hold(1'b1, 1'b1, 15);
    hold(1'b0, 1'b1, 15);
    tick(1'b0, 1'b1, 1'b1);
    check("rstmid.busy", 16'(busy), 16'd0);
    check("rstmid.entryCount", entryCount, 16'd0);
    hold(1'b0, 1'b0, 20);
    check("rstmid.noEnter", 16'(dEnter), 16'd0);

    // Beam still blocked across reset is treated as a fresh block
    clrObs();
    tick(1'b1, 1'b0, 1'b1);
    hold(1'b1, 1'b0, 20);
    hold(1'b0, 1'b0, 20);
    check("rstblocked.abort", 16'(dAbort), 16'd1);

`ifdef PIR_DIR_STATS_EN
    // Saturation: preload near full scale, then two more entries
    force dut.entryCountReg = 16'hFFFE;
    #1 release dut.entryCountReg;
    mEntry = 16'hFFFE;
    for (int k = 0; k < 2; k++) begin
      hold(1'b1, 1'b0, 10);
      hold(1'b1, 1'b1, 10);
      hold(1'b0, 1'b1, 10);
      hold(1'b0, 1'b0, 12);
    end
    check("sat.entryCount", entryCount, 16'hFFFF);
`endif

    // Random beam activity
    for (int s = 0; s < 60; s++) begin
      ro = 1'($urandom_range(0, 1));
      ri = 1'($urandom_range(0, 1));
      hold(ro, ri, int'($urandom_range(1, 25)));
    end
    hold(1'b0, 1'b0, 80);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
